// File: rtl/x_serializer.sv
// Parallel-to-serial front end for the 3-bit sequence detector: accepts a word over
// valid/ready and drives it MSB-first on x, one bit per CLK, with stall and gap-free chaining.
module x_serializer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] words_sent
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   words_q, words_d;
    logic               x_q, x_d;
    logic               x_valid_q, x_valid_d;
    logic               busy_q, busy_d;

    logic               last_bit_s;
    logic               ready_s;
    logic               accept_s;

    // Last bit is consumed only when the final index is reached and the shift is enabled.
    always_comb begin
        last_bit_s = (state_q == ST_SHIFT) && (idx_q == {IDX_W{1'b0}}) && shift_en;
        ready_s    = (state_q == ST_IDLE) || last_bit_s;
        accept_s   = load_valid && ready_s;
    end

    // State and datapath registers; RESET wins over every other input.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            shreg_q   <= {WIDTH{1'b0}};
            idx_q     <= {IDX_W{1'b0}};
            words_q   <= {CNT_W{1'b0}};
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            idx_q     <= idx_d;
            words_q   <= words_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_bit_s && !accept_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Shift register, bit index and word counter next values.
    always_comb begin
        shreg_d = shreg_q;
        idx_d   = idx_q;
        words_d = words_q;
        if (accept_s) begin
            shreg_d = data_in;
            idx_d   = IDX_LAST;
        end else if ((state_q == ST_SHIFT) && shift_en && (idx_q != {IDX_W{1'b0}})) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            idx_d   = idx_q - {{(IDX_W-1){1'b0}}, 1'b1};
        end else begin
            shreg_d = shreg_q;
            idx_d   = idx_q;
        end
        if (last_bit_s) begin
            words_d = words_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            words_d = words_q;
        end
    end

    // Outputs: x/x_valid/busy are registered from the next state so x never glitches downstream.
    always_comb begin
        if (state_d == ST_SHIFT) begin
            x_d       = shreg_d[WIDTH-1];
            x_valid_d = 1'b1;
            busy_d    = 1'b1;
        end else begin
            x_d       = 1'b0;
            x_valid_d = 1'b0;
            busy_d    = 1'b0;
        end
        load_ready = ready_s;
        done       = last_bit_s;
        x          = x_q;
        x_valid    = x_valid_q;
        busy       = busy_q;
        words_sent = words_q;
    end

endmodule

// File: tb/tb_x_serializer.sv
// Directed self-checking bench for x_serializer; a second instance with CNT_W=2 covers counter wrap.
module tb_x_serializer;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] data_in;
    logic       load_valid;
    logic       shift_en;
    logic       load_ready, x, x_valid, busy, done;
    logic [7:0] words_sent;
    logic       load_ready2, x2, x_valid2, busy2, done2;
    logic [1:0] words_sent2;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_words;

    always #5 CLK = ~CLK;

    x_serializer #(.WIDTH(8), .CNT_W(8)) u_dut (
        .CLK(CLK), .RESET(RESET), .data_in(data_in), .load_valid(load_valid),
        .load_ready(load_ready), .shift_en(shift_en), .x(x), .x_valid(x_valid),
        .busy(busy), .done(done), .words_sent(words_sent)
    );

    x_serializer #(.WIDTH(8), .CNT_W(2)) u_dut2 (
        .CLK(CLK), .RESET(RESET), .data_in(data_in), .load_valid(load_valid),
        .load_ready(load_ready2), .shift_en(shift_en), .x(x2), .x_valid(x_valid2),
        .busy(busy2), .done(done2), .words_sent(words_sent2)
    );

    task automatic test_reset;
        RESET = 1'b1; load_valid = 1'b0; shift_en = 1'b1; data_in = 8'h00;
        @(negedge CLK); @(negedge CLK);
        RESET = 1'b0;
        #1;
        checks++;
        if (x !== 1'b0 || x_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs: x=%b xv=%b busy=%b done=%b rdy=%b want 0 0 0 0 1",
                     x, x_valid, busy, done, load_ready);
        end
        checks++;
        if (words_sent !== 8'd0) begin
            errors++; $display("FAIL reset_count: got %0d want 0", words_sent);
        end
        exp_words = 8'd0;
        @(negedge CLK);
    endtask

    task automatic test_single;
        logic [7:0] w;
        w = 8'b1011_0010;
        data_in = w; load_valid = 1'b1; shift_en = 1'b1;
        #1;
        checks++;
        if (load_ready !== 1'b1) begin
            errors++; $display("FAIL single_ready_idle: got %b want 1", load_ready);
        end
        @(negedge CLK);
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (x !== w[7-i] || x_valid !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL single_bit%0d: x=%b xv=%b busy=%b want %b 1 1", i, x, x_valid, busy, w[7-i]);
            end
            checks++;
            if (done !== (i == 7)) begin
                errors++; $display("FAIL single_done%0d: got %b want %b", i, done, (i == 7));
            end
            @(negedge CLK);
        end
        exp_words = exp_words + 8'd1;
        #1;
        checks++;
        if (words_sent !== exp_words || x_valid !== 1'b0 || busy !== 1'b0 || x !== 1'b0) begin
            errors++;
            $display("FAIL single_after: cnt=%0d xv=%b busy=%b x=%b want %0d 0 0 0", words_sent, x_valid, busy, x, exp_words);
        end
        @(negedge CLK);
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp;
        exp = 16'b1111_0000_0000_1111;
        data_in = 8'hF0; load_valid = 1'b1; shift_en = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < 16; i++) begin
            if (i < 8) begin
                data_in = 8'h0F; load_valid = 1'b1;
            end else begin
                load_valid = 1'b0;
            end
            #1;
            checks++;
            if (x !== exp[15-i] || x_valid !== 1'b1) begin
                errors++; $display("FAIL b2b_bit%0d: x=%b xv=%b want %b 1", i, x, x_valid, exp[15-i]);
            end
            checks++;
            if (done !== (i == 7 || i == 15) || load_ready !== (i == 7 || i == 15)) begin
                errors++;
                $display("FAIL b2b_done%0d: done=%b rdy=%b want %b", i, done, load_ready, (i == 7 || i == 15));
            end
            @(negedge CLK);
        end
        exp_words = exp_words + 8'd2;
        #1;
        checks++;
        if (words_sent !== exp_words || x_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_after: cnt=%0d xv=%b want %0d 0", words_sent, x_valid, exp_words);
        end
        @(negedge CLK);
    endtask

    task automatic test_stall;
        logic [10:0] exp;
        exp = 11'b101_1110_0101;
        data_in = 8'hA5; load_valid = 1'b1; shift_en = 1'b1;
        @(negedge CLK);
        load_valid = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            shift_en = !(c >= 3 && c <= 5);
            #1;
            checks++;
            if (x !== exp[11-c] || x_valid !== 1'b1) begin
                errors++; $display("FAIL stall_cyc%0d: x=%b xv=%b want %b 1", c, x, x_valid, exp[11-c]);
            end
            checks++;
            if (load_ready !== (c == 11) || done !== (c == 11)) begin
                errors++;
                $display("FAIL stall_rdy%0d: rdy=%b done=%b want %b", c, load_ready, done, (c == 11));
            end
            @(negedge CLK);
        end
        shift_en = 1'b1;
        exp_words = exp_words + 8'd1;
        #1;
        checks++;
        if (words_sent !== exp_words || busy !== 1'b0) begin
            errors++; $display("FAIL stall_after: cnt=%0d busy=%b want %0d 0", words_sent, busy, exp_words);
        end
        @(negedge CLK);
    endtask

    task automatic test_busy_reject;
        logic [7:0] w;
        w = 8'h3C;
        data_in = w; load_valid = 1'b1; shift_en = 1'b1;
        @(negedge CLK);
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2 || i == 3) begin
                data_in = 8'hFF; load_valid = 1'b1;
            end else begin
                load_valid = 1'b0;
            end
            #1;
            checks++;
            if (x !== w[7-i] || done !== (i == 7)) begin
                errors++; $display("FAIL reject_bit%0d: x=%b done=%b want %b %b", i, x, done, w[7-i], (i == 7));
            end
            @(negedge CLK);
        end
        load_valid = 1'b0;
        exp_words = exp_words + 8'd1;
        #1;
        checks++;
        if (words_sent !== exp_words || x_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reject_after: cnt=%0d xv=%b busy=%b want %0d 0 0", words_sent, x_valid, busy, exp_words);
        end
        @(negedge CLK);
    endtask

    task automatic test_reset_mid;
        logic [7:0] w;
        w = 8'hC3;
        data_in = w; load_valid = 1'b1; shift_en = 1'b1;
        @(negedge CLK);
        load_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (x !== w[7-i]) begin
                errors++; $display("FAIL rstmid_bit%0d: x=%b want %b", i, x, w[7-i]);
            end
            @(negedge CLK);
        end
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        checks++;
        if (x !== 1'b0 || x_valid !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_outputs: x=%b xv=%b busy=%b rdy=%b done=%b want 0 0 0 1 0",
                     x, x_valid, busy, load_ready, done);
        end
        checks++;
        if (words_sent !== 8'd0) begin
            errors++; $display("FAIL rstmid_count: got %0d want 0", words_sent);
        end
        exp_words = 8'd0;
        w = 8'h5A;
        data_in = w; load_valid = 1'b1;
        @(negedge CLK);
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (x !== w[7-i] || x_valid !== 1'b1 || done !== (i == 7)) begin
                errors++;
                $display("FAIL rstmid_reload%0d: x=%b xv=%b done=%b want %b 1 %b", i, x, x_valid, done, w[7-i], (i == 7));
            end
            @(negedge CLK);
        end
        exp_words = exp_words + 8'd1;
        #1;
        checks++;
        if (words_sent !== exp_words) begin
            errors++; $display("FAIL rstmid_reload_cnt: got %0d want %0d", words_sent, exp_words);
        end
        @(negedge CLK);
    endtask

    task automatic test_wrap;
        logic [1:0] seq [5];
        seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        RESET = 1'b1; load_valid = 1'b0; shift_en = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        for (int k = 0; k < 5; k++) begin
            data_in = 8'h81 + 8'(k); load_valid = 1'b1;
            @(negedge CLK);
            load_valid = 1'b0;
            for (int i = 0; i < 8; i++) @(negedge CLK);
            #1;
            checks++;
            if (words_sent2 !== seq[k] || x_valid2 !== 1'b0) begin
                errors++;
                $display("FAIL wrap_word%0d: cnt=%0d xv=%b want %0d 0", k, words_sent2, x_valid2, seq[k]);
            end
        end
        checks++;
        if (words_sent !== 8'd5) begin
            errors++; $display("FAIL wrap_wide_cnt: got %0d want 5", words_sent);
        end
        @(negedge CLK);
    endtask

    initial begin
        RESET = 1'b1; data_in = 8'h00; load_valid = 1'b0; shift_en = 1'b1;
        exp_words = 8'd0;
        @(negedge CLK);
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_busy_reject();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
